// File: rtl/gemm_pkg.sv
// Shared parameters and state encoding for the matrix-vector scheduler.
package gemm_pkg;

    localparam int unsigned DATA_W = 27;
    localparam int unsigned LEN    = 32;
    localparam int unsigned ROWS   = 32;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = 64;

    localparam int unsigned VEC_AW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int unsigned MAT_AW = (ROWS * LEN > 1) ? $clog2(ROWS * LEN) : 1;
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HOLD
    } state_t;

endpackage

// File: rtl/gemm_mac_lane.sv
// Single signed multiply-accumulate lane: operand stage, registered product,
// wrapping accumulator.
module gemm_mac_lane
    import gemm_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] vec,
    input  logic signed [DATA_W-1:0] mat,
    output logic signed [ACC_W-1:0]  acc,
    output logic                     acc_valid
);

    logic                     v1;
    logic                     c1;
    logic                     v2;
    logic                     c2;
    logic signed [PROD_W-1:0] prod;

    // Stage 1 operands are the RAM output registers; v1/c1 travel alongside them.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            c1        <= 1'b0;
            v2        <= 1'b0;
            c2        <= 1'b0;
            prod      <= '0;
            acc       <= '0;
            acc_valid <= 1'b0;
        end else begin
            v1 <= in_valid;
            c1 <= clr;
            v2 <= v1;
            c2 <= c1;
            if (v1) begin
                prod <= PROD_W'(vec) * PROD_W'(mat);
            end
            if (v2) begin
                acc <= c2 ? ACC_W'(prod) : acc + ACC_W'(prod);
            end
            // Set once the last product has landed and nothing newer is in flight.
            acc_valid <= !in_valid && !v1 && (v2 || acc_valid);
        end
    end

endmodule

// File: rtl/gemm_mv_sched.sv
// Matrix-vector scheduler: streams one row at a time through a single MAC lane
// and hands each row's dot product to the writeback over valid/ready.
module gemm_mv_sched
    import gemm_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_valid,
    output logic                     start_ready,
    output logic                     vec_rd_en,
    output logic [VEC_AW-1:0]        vec_rd_addr,
    input  logic signed [DATA_W-1:0] vec_rd_data,
    output logic                     mat_rd_en,
    output logic [MAT_AW-1:0]        mat_rd_addr,
    input  logic signed [DATA_W-1:0] mat_rd_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [ACC_W-1:0]  res_data,
    output logic [ROW_W-1:0]         res_row,
    output logic                     res_last,
    output logic                     busy
);

    state_t state;
    logic   rd_en;
    logic   drain_second;
    logic   first_k;
    logic   acc_valid;

    assign vec_rd_en = rd_en;
    assign mat_rd_en = rd_en;
    assign first_k   = rd_en && (vec_rd_addr == '0);

    gemm_mac_lane u_lane (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_en),
        .clr       (first_k),
        .vec       (vec_rd_data),
        .mat       (mat_rd_data),
        .acc       (res_data),
        .acc_valid (acc_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            start_ready  <= 1'b1;
            busy         <= 1'b0;
            rd_en        <= 1'b0;
            vec_rd_addr  <= '0;
            mat_rd_addr  <= '0;
            res_valid    <= 1'b0;
            res_row      <= '0;
            res_last     <= 1'b0;
            drain_second <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        state       <= RUN;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        rd_en       <= 1'b1;
                        vec_rd_addr <= '0;
                        mat_rd_addr <= '0;
                        res_row     <= '0;
                    end
                end
                RUN: begin
                    if (vec_rd_addr == VEC_AW'(LEN - 1)) begin
                        state        <= DRAIN;
                        rd_en        <= 1'b0;
                        drain_second <= 1'b0;
                    end else begin
                        vec_rd_addr <= vec_rd_addr + VEC_AW'(1);
                        mat_rd_addr <= mat_rd_addr + MAT_AW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_second) begin
                        state     <= HOLD;
                        res_valid <= 1'b1;
                        res_last  <= (res_row == ROW_W'(ROWS - 1));
                    end else begin
                        drain_second <= 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_last  <= 1'b0;
                        if (res_row == ROW_W'(ROWS - 1)) begin
                            state       <= IDLE;
                            start_ready <= 1'b1;
                            busy        <= 1'b0;
                            res_row     <= '0;
                            vec_rd_addr <= '0;
                            mat_rd_addr <= '0;
                        end else begin
                            // Matrix rows are contiguous, so the address just keeps counting.
                            state       <= RUN;
                            rd_en       <= 1'b1;
                            res_row     <= res_row + ROW_W'(1);
                            vec_rd_addr <= '0;
                            mat_rd_addr <= mat_rd_addr + MAT_AW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    res_holds_final_sum: assert property (@(posedge clk) disable iff (rst) res_valid |-> acc_valid);

endmodule
